// File: rtl/board_renderer.sv
// Two-stage playfield pixel renderer: tracks tile position with counters, snapshots
// the game state once per frame and colours each pixel by cell/piece/grid priority.
module board_renderer #(
  parameter int MIN_X      = 200,
  parameter int MIN_Y      = 0,
  parameter int TILE_WIDTH = 20,
  parameter int COLS       = 20,
  parameter int ROWS       = 20,
  parameter int H_TOTAL    = 800,
  parameter int V_TOTAL    = 525
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [9:0]                 DrawX,
  input  logic [9:0]                 DrawY,
  input  logic                       blank,
  input  logic [0:ROWS-1][COLS-1:0]  board_in,
  input  logic [39:0]                piece_relX,
  input  logic [39:0]                piece_relY,
  input  logic [9:0]                 posX,
  input  logic [9:0]                 posY,
  input  logic                       game_over,
  output logic [3:0]                 Red,
  output logic [3:0]                 Green,
  output logic [3:0]                 Blue,
  output logic                       pix_valid
);

  localparam int SUB_W = $clog2(TILE_WIDTH);
  localparam int COL_W = $clog2(COLS + 1);
  localparam int ROW_W = $clog2(ROWS + 1);
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(TILE_WIDTH - 1);
  localparam logic [COL_W-1:0] COL_SAT  = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_SAT  = ROW_W'(ROWS);

  logic snap;
  assign snap = (DrawX == 10'd0) && (DrawY == 10'd0);

  // Frame snapshot of the game state
  logic [0:ROWS-1][COLS-1:0] board_sh_reg;
  logic [39:0]               relx_sh_reg;
  logic [39:0]               rely_sh_reg;
  logic [9:0]                posx_sh_reg;
  logic [9:0]                posy_sh_reg;
  logic                      go_sh_reg;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      board_sh_reg <= '0;
      relx_sh_reg  <= '0;
      rely_sh_reg  <= '0;
      posx_sh_reg  <= '0;
      posy_sh_reg  <= '0;
      go_sh_reg    <= 1'b0;
    end else if (snap) begin
      board_sh_reg <= board_in;
      relx_sh_reg  <= piece_relX;
      rely_sh_reg  <= piece_relY;
      posx_sh_reg  <= posX;
      posy_sh_reg  <= posY;
      go_sh_reg    <= game_over;
    end
  end

  // Stage 1: raster position and tile trackers
  logic [9:0]       draw_x_reg, draw_y_reg;
  logic             blank_reg;
  logic [SUB_W-1:0] sub_x_reg, sub_x_next, sub_y_reg, sub_y_next;
  logic [COL_W-1:0] col_reg, col_next;
  logic [ROW_W-1:0] row_reg, row_next;

  always_comb begin
    sub_x_next = sub_x_reg;
    col_next   = col_reg;
    if (DrawX == 10'(MIN_X)) begin
      sub_x_next = '0;
      col_next   = '0;
    end else if (sub_x_reg == SUB_LAST) begin
      sub_x_next = '0;
      if (col_reg != COL_SAT) col_next = col_reg + 1'b1;
    end else begin
      sub_x_next = sub_x_reg + 1'b1;
    end
  end

  // Vertical trackers only move at the start of each line
  always_comb begin
    sub_y_next = sub_y_reg;
    row_next   = row_reg;
    if (snap) begin
      sub_y_next = '0;
      row_next   = '0;
    end else if (DrawX == 10'd0) begin
      if (sub_y_reg == SUB_LAST) begin
        sub_y_next = '0;
        if (row_reg != ROW_SAT) row_next = row_reg + 1'b1;
      end else begin
        sub_y_next = sub_y_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      draw_x_reg <= '0;
      draw_y_reg <= '0;
      blank_reg  <= 1'b0;
      sub_x_reg  <= '0;
      sub_y_reg  <= '0;
      col_reg    <= COL_SAT;
      row_reg    <= ROW_SAT;
    end else begin
      draw_x_reg <= DrawX;
      draw_y_reg <= DrawY;
      blank_reg  <= blank;
      sub_x_reg  <= sub_x_next;
      sub_y_reg  <= sub_y_next;
      col_reg    <= col_next;
      row_reg    <= row_next;
    end
  end

  // Stage 2: classify the stage-1 pixel
  logic [10:0] px11, py11, y_off;
  logic        in_field;
  logic        locked;
  logic        bevel;
  logic [3:0]  hit;

  assign px11  = {1'b0, draw_x_reg};
  assign py11  = {1'b0, draw_y_reg};
  assign y_off = py11 - 11'(MIN_Y);

  assign in_field = (col_reg < COL_SAT) && (row_reg < ROW_SAT) &&
                    (px11 < 11'(H_TOTAL)) && (py11 < 11'(V_TOTAL)) &&
                    (y_off < 11'(ROWS * TILE_WIDTH));

  assign locked = in_field && board_sh_reg[row_reg][col_reg];
  assign bevel  = (sub_x_reg == '0) || (sub_x_reg == SUB_LAST) ||
                  (sub_y_reg == '0) || (sub_y_reg == SUB_LAST);

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_piece
      logic [10:0] lo_x, lo_y;
      assign lo_x = {1'b0, posx_sh_reg} + 11'(relx_sh_reg[gi*10 +: 10]) * 11'(TILE_WIDTH);
      assign lo_y = {1'b0, posy_sh_reg} + 11'(rely_sh_reg[gi*10 +: 10]) * 11'(TILE_WIDTH);
      assign hit[gi] = (px11 >= lo_x) && (px11 < lo_x + 11'(TILE_WIDTH)) &&
                       (py11 >= lo_y) && (py11 < lo_y + 11'(TILE_WIDTH));
    end
  endgenerate

  logic [11:0] rgb_next;

  always_comb begin
    rgb_next = 12'h000;
    if (!blank_reg) begin
      rgb_next = 12'h000;
    end else if (!in_field) begin
      rgb_next = 12'h222;
    end else if (|hit) begin
      rgb_next = 12'hFF0;
    end else if (locked) begin
      if (bevel)          rgb_next = 12'h088;
      else if (go_sh_reg) rgb_next = 12'hF00;
      else                rgb_next = 12'h0FF;
    end else if ((sub_x_reg == '0) || (sub_y_reg == '0)) begin
      rgb_next = 12'h111;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Red       <= 4'h0;
      Green     <= 4'h0;
      Blue      <= 4'h0;
      pix_valid <= 1'b0;
    end else begin
      Red       <= rgb_next[11:8];
      Green     <= rgb_next[7:4];
      Blue      <= rgb_next[3:0];
      pix_valid <= blank_reg;
    end
  end

endmodule

// File: tb/tb_board_renderer.sv
// Drives partial raster frames into board_renderer and checks every pixel, two cycles
// later, against a per-pixel arithmetic model of the colouring rules.
module tb_board_renderer;

  logic                 Clk = 1'b0;
  logic                 Reset_n = 1'b0;
  logic [9:0]           DrawX, DrawY;
  logic                 blank;
  logic [0:19][19:0]    board_in;
  logic [39:0]          piece_relX, piece_relY;
  logic [9:0]           posX, posY;
  logic                 game_over;
  logic [3:0]           Red, Green, Blue;
  logic                 pix_valid;

  board_renderer dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .board_in(board_in), .piece_relX(piece_relX), .piece_relY(piece_relY),
    .posX(posX), .posY(posY), .game_over(game_over),
    .Red(Red), .Green(Green), .Blue(Blue), .pix_valid(pix_valid)
  );

  always #5 Clk = ~Clk;

  int tests = 0;
  int fails = 0;
  int cur_frame = 0;

  // Reference model state: the snapshot the model believes is in effect
  logic [0:19][19:0] m_board;
  int  m_relx[4];
  int  m_rely[4];
  int  m_posx, m_posy;
  bit  m_go, m_snapped;

  typedef struct { bit v; int f; int x; int y; logic [12:0] exp; } ent_t;
  ent_t h1, h2;

  typedef struct { int f; int x; int y; logic [11:0] rgb; } dir_t;
  dir_t dirs[$];

  int full_rows[19] = '{0, 1, 7, 19, 20, 26, 27, 46, 47, 100, 105, 119, 120,
                        200, 201, 399, 400, 450, 524};

  function automatic logic [12:0] ref_pix(int x, int y, bit b);
    int col, row, sx, sy;
    bit act;
    if (!b) return 13'h0000;
    if (!m_snapped || x < 200 || x >= 600 || y >= 400) return {1'b1, 12'h222};
    col = (x - 200) / 20;
    sx  = (x - 200) % 20;
    row = y / 20;
    sy  = y % 20;
    act = 1'b0;
    for (int k = 0; k < 4; k++) begin
      int lx = m_posx + m_relx[k] * 20;
      int ly = m_posy + m_rely[k] * 20;
      if (x >= lx && x < lx + 20 && y >= ly && y < ly + 20) act = 1'b1;
    end
    if (act) return {1'b1, 12'hFF0};
    if (m_board[row][col]) begin
      if (sx == 0 || sx == 19 || sy == 0 || sy == 19) return {1'b1, 12'h088};
      return m_go ? {1'b1, 12'hF00} : {1'b1, 12'h0FF};
    end
    if (sx == 0 || sy == 0) return {1'b1, 12'h111};
    return {1'b1, 12'h000};
  endfunction

  task automatic check_out(string tag, logic [12:0] exp);
    logic [12:0] obs;
    obs = {pix_valid, Red, Green, Blue};
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed pv/rgb=%h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_h2();
    if (h2.v) begin
      check_out($sformatf("pix(%0d,%0d) frame%0d", h2.x, h2.y, h2.f), h2.exp);
      foreach (dirs[i])
        if (dirs[i].f == h2.f && dirs[i].x == h2.x && dirs[i].y == h2.y)
          check_out($sformatf("directed(%0d,%0d) frame%0d", h2.x, h2.y, h2.f), {1'b1, dirs[i].rgb});
    end
  endtask

  task automatic pix_cycle(int x, int y, bit b);
    compare_h2();
    h2 = h1;
    DrawX = 10'(x);
    DrawY = 10'(y);
    blank = b;
    if (x == 0 && y == 0) begin
      m_board = board_in;
      for (int k = 0; k < 4; k++) begin
        m_relx[k] = int'(piece_relX[k*10 +: 10]);
        m_rely[k] = int'(piece_relY[k*10 +: 10]);
      end
      m_posx = int'(posX);
      m_posy = int'(posY);
      m_go = game_over;
      m_snapped = 1'b1;
    end
    h1 = '{1'b1, cur_frame, x, y, ref_pix(x, y, b)};
  endtask

  task automatic step(int x, int y, bit b);
    @(negedge Clk);
    pix_cycle(x, y, b);
  endtask

  task automatic apply_reset(int hold);
    @(negedge Clk);
    compare_h2();
    Reset_n = 1'b0;
    #1;
    check_out("reset_async", 13'h0000);
    m_board = '0;
    for (int k = 0; k < 4; k++) begin
      m_relx[k] = 0;
      m_rely[k] = 0;
    end
    m_posx = 0;
    m_posy = 0;
    m_go = 1'b0;
    m_snapped = 1'b0;
    h1.v = 1'b0;
    h2.v = 1'b0;
    repeat (hold) begin
      @(negedge Clk);
      check_out("reset_hold", 13'h0000);
    end
    @(negedge Clk);
    Reset_n = 1'b1;
    // First output after release comes from the cleared stage-1 registers
    h1 = '{1'b1, cur_frame, -1, -1, 13'h0000};
    pix_cycle(int'(DrawX), int'(DrawY), blank);
  endtask

  task automatic full_line(int y, int rst_x);
    step(0, y, 1'b1);
    for (int x = 195; x <= 610; x++) begin
      if (x == rst_x) apply_reset(2);
      step(x, y, 1'b1);
    end
    for (int x = 640; x <= 645; x++) step(x, y, 1'b0);
    for (int x = 800; x <= 802; x++) step(x, y, 1'b1);
  endtask

  task automatic run_frame(int change_y, int rst_y);
    bit full;
    for (int y = 0; y < 525; y++) begin
      if (y == change_y) begin
        for (int r = 0; r < 20; r++)
          for (int c = 0; c < 20; c++)
            board_in[r][c] = ($urandom_range(0, 2) == 0);
      end
      full = 1'b0;
      foreach (full_rows[i]) if (full_rows[i] == y) full = 1'b1;
      if (full) full_line(y, (y == rst_y) ? 300 : -1);
      else      step(0, y, 1'b1);
    end
    $display("[TB] frame %0d done: %0d tests, %0d failed so far", cur_frame, tests, fails);
  endtask

  task automatic randomize_piece();
    for (int k = 0; k < 4; k++) begin
      piece_relX[k*10 +: 10] = 10'($urandom_range(0, 3));
      piece_relY[k*10 +: 10] = 10'($urandom_range(0, 3));
    end
    posX = 10'($urandom_range(150, 650));
    posY = 10'($urandom_range(0, 420));
    game_over = 1'($urandom_range(0, 1));
  endtask

  initial begin
    h1 = '{1'b0, 0, 0, 0, 13'h0000};
    h2 = '{1'b0, 0, 0, 0, 13'h0000};
    DrawX = 10'd1023;
    DrawY = 10'd1023;
    blank = 1'b0;
    board_in = '0;
    piece_relX = {10'd1, 10'd2, 10'd1, 10'd0};
    piece_relY = {10'd1, 10'd0, 10'd0, 10'd0};
    posX = 10'd360;
    posY = 10'd500;
    game_over = 1'b0;

    dirs.push_back('{1, 200, 0, 12'h111});
    dirs.push_back('{1, 210, 10, 12'h000});
    dirs.push_back('{1, 599, 399, 12'h000});
    dirs.push_back('{1, 200, 400, 12'h222});
    dirs.push_back('{2, 380, 27, 12'hFF0});
    dirs.push_back('{2, 399, 46, 12'hFF0});
    dirs.push_back('{2, 400, 27, 12'h111});
    dirs.push_back('{2, 380, 47, 12'h111});
    dirs.push_back('{2, 359, 7, 12'h000});
    dirs.push_back('{2, 260, 100, 12'h088});
    dirs.push_back('{2, 265, 105, 12'h0FF});
    dirs.push_back('{2, 279, 119, 12'h088});
    dirs.push_back('{2, 280, 105, 12'h111});
    dirs.push_back('{2, 199, 105, 12'h222});
    dirs.push_back('{2, 600, 105, 12'h222});
    dirs.push_back('{3, 265, 105, 12'hF00});
    dirs.push_back('{3, 260, 105, 12'h088});

    apply_reset(3);

    cur_frame = 1;               // empty board, piece below the playfield
    run_frame(-1, -1);

    cur_frame = 2;               // one locked cell and a T piece
    board_in[5][3] = 1'b1;
    posY = 10'd7;
    run_frame(-1, -1);

    cur_frame = 3;               // game over; board changes mid-frame
    game_over = 1'b1;
    run_frame(200, -1);

    cur_frame = 4;               // new board becomes visible, random piece
    randomize_piece();
    run_frame(-1, -1);

    cur_frame = 5;               // reset mid-line
    randomize_piece();
    run_frame(-1, 100);

    cur_frame = 6;
    randomize_piece();
    run_frame(-1, -1);

    step(1023, 1023, 1'b0);
    step(1023, 1023, 1'b0);
    step(1023, 1023, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
